// File: rtl/dmem_arb_pkg.sv
// Shared types for the M-stage data-memory lane arbiter: state encoding and lane selects.
// Read by dmem_lane_arbiter; the optional load merge is controlled by DMEM_LOADMERGE_EN.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } arb_state_e;

  localparam logic LANE_ODD  = 1'b0;
  localparam logic LANE_EVEN = 1'b1;

  // Two byte addresses fall in the same 32-bit word.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/dmem_lane_arbiter_if.sv
// M-stage lane request / data-memory bus seen by dmem_lane_arbiter.
// slave: the arbiter; master: the pipeline plus memory environment driving it.
interface dmem_lane_arbiter_if;

  logic        memreqmODD;
  logic        memreqmEVEN;
  logic        memwritemODD;
  logic        memwritemEVEN;
  logic [31:0] aluoutmODD;
  logic [31:0] aluoutmEVEN;
  logic [31:0] writedatamODD;
  logic [31:0] writedatamEVEN;
  logic [31:0] readdatamODD;
  logic [31:0] readdatamEVEN;
  logic        stallm;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic        dmem_we;
  logic [31:0] dmem_rd;

  modport slave (
    input  memreqmODD, memreqmEVEN, memwritemODD, memwritemEVEN,
    input  aluoutmODD, aluoutmEVEN, writedatamODD, writedatamEVEN,
    input  dmem_rd,
    output readdatamODD, readdatamEVEN, stallm,
    output dmem_a, dmem_wd, dmem_we
  );

  modport master (
    output memreqmODD, memreqmEVEN, memwritemODD, memwritemEVEN,
    output aluoutmODD, aluoutmEVEN, writedatamODD, writedatamEVEN,
    output dmem_rd,
    input  readdatamODD, readdatamEVEN, stallm,
    input  dmem_a, dmem_wd, dmem_we
  );

endinterface

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to zero.
module flopenr #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/mux2.sv
// Two-input multiplexer; s_i=1 selects d1_i.
module mux2 #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] d0_i,
  input  logic [Width-1:0] d1_i,
  input  logic             s_i,
  output logic [Width-1:0] y_o
);

  assign y_o = s_i ? d1_i : d0_i;

endmodule

// File: rtl/dmem_lane_arbiter.sv
// Shares one single-ported data memory between the ODD and EVEN M-stage lanes, serialising
// dual accesses ODD-then-EVEN with a one-cycle stall. DMEM_LOADMERGE_EN merges same-word loads.
module dmem_lane_arbiter
  import dmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  dmem_lane_arbiter_if.slave   bus
);

  arb_state_e  state_q, state_d;
  logic        merge;
  logic        conflict;
  logic        lane_sel;
  logic        stall;
  logic        we;
  logic        hold_sel;
  logic [31:0] hold_q;
  logic [31:0] addr_mux;
  logic [31:0] wd_mux;
  logic [31:0] rd_odd_mux;

`ifdef DMEM_LOADMERGE_EN
  assign merge = ~bus.memwritemODD & ~bus.memwritemEVEN &
                 same_word(bus.aluoutmODD, bus.aluoutmEVEN);
`else
  assign merge = 1'b0;
`endif

  assign conflict = bus.memreqmODD & bus.memreqmEVEN & ~merge;

  always_comb begin
    state_d  = state_q;
    lane_sel = LANE_ODD;
    stall    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (conflict) begin
          stall   = 1'b1;
          state_d = ARB_SECOND;
        end else if (bus.memreqmEVEN && !bus.memreqmODD) begin
          lane_sel = LANE_EVEN;
        end
      end
      ARB_SECOND: begin
        lane_sel = LANE_EVEN;
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    // Only the granted lane may write; a merged pair is two loads so never writes.
    we = (lane_sel == LANE_EVEN) ? (bus.memreqmEVEN & bus.memwritemEVEN)
                                 : (bus.memreqmODD & bus.memwritemODD);

    // Reset also aborts a pending EVEN access in ARB_SECOND.
    if (reset) begin
      stall = 1'b0;
      we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // stall is only high on the ARB_IDLE conflict cycle, which is exactly when ODD's data lands.
  flopenr #(.Width(32)) u_hold (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (stall),
    .d_i     (bus.dmem_rd),
    .q_o     (hold_q)
  );

  mux2 #(.Width(32)) u_addr_mux (
    .d0_i (bus.aluoutmODD),
    .d1_i (bus.aluoutmEVEN),
    .s_i  (lane_sel),
    .y_o  (addr_mux)
  );

  mux2 #(.Width(32)) u_wd_mux (
    .d0_i (bus.writedatamODD),
    .d1_i (bus.writedatamEVEN),
    .s_i  (lane_sel),
    .y_o  (wd_mux)
  );

  assign hold_sel = (state_q == ARB_SECOND);

  mux2 #(.Width(32)) u_rd_odd_mux (
    .d0_i (bus.dmem_rd),
    .d1_i (hold_q),
    .s_i  (hold_sel),
    .y_o  (rd_odd_mux)
  );

  assign bus.dmem_a        = addr_mux;
  assign bus.dmem_wd       = wd_mux;
  assign bus.dmem_we       = we;
  assign bus.stallm        = stall;
  assign bus.readdatamODD  = rd_odd_mux;
  assign bus.readdatamEVEN = bus.dmem_rd;

endmodule

// File: doc/dmem_lane_arbiter.md
# dmem_lane_arbiter

Shares one single-ported data memory between the ODD and EVEN lanes of the dual-issue pipeline at the M stage. Requests from one lane pass straight through with no added latency. When both lanes access memory in the same cycle, the block serialises them in program order (ODD, then EVEN) and asserts a one-cycle pipeline stall. It sits between the M-stage pipeline registers and the data memory, and feeds the hazard unit.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- memreqmODD / memreqmEVEN  in  1  lane performs a memory access this M cycle (load or store)
- memwritemODD / memwritemEVEN  in  1  access is a store (valid only with memreq)
- aluoutmODD / aluoutmEVEN  in  32  byte address
- writedatamODD / writedatamEVEN  in  32  store data
- readdatamODD / readdatamEVEN  out  32  load data returned to each lane's M→W register
- stallm  out  1  freeze F, D, E and M registers; insert bubble into M→W
- dmem_a  out  32  memory address
- dmem_wd  out  32  memory write data
- dmem_we  out  1  memory write enable
- dmem_rd  in  32  memory read data (combinational read, write on rising clk)

## Operation
- Lane n requests when memreqmn=1. Conflict = both lanes request, and no merge applies (see Configuration).
- States: ARB_IDLE, ARB_SECOND.
- ARB_IDLE:
  - With no requests: dmem_we=0 and dmem_a=aluoutmODD, readdata outputs = dmem_rd.
  - With a single request: the requesting lane drives dmem_a, dmem_wd and dmem_we. Its readdata = dmem_rd. stallm=0.
  - On a conflict: ODD drives memory. dmem_rd is captured into hold register on the edge. stallm=1. Next state is ARB_SECOND.
- ARB_SECOND:
  - The M-stage inputs are frozen by the stall, so they equal the values from the conflict cycle.
  - EVEN drives memory. readdatamEVEN=dmem_rd and readdatamODD=hold. stallm=0.
  - Next state is always ARB_IDLE.
- Program-order guarantee: an ODD store followed by an EVEN load to the same word returns the new data to EVEN. An EVEN store never precedes an ODD access.
- At most one write per cycle. dmem_we is never asserted for a non-granted lane.
- readdata of a lane that made no request, or made a store, equals dmem_rd and has no meaning.

## Timing
- Single access: 0 added cycles. The addr→rd path is combinational through the block.
- Conflict: 2 cycles total, with stallm high in the first cycle only. Both lanes' load results are valid together in the ARB_SECOND cycle.
- The hold register updates only on the ARB_IDLE conflict edge.
- Reset:
  - State goes to ARB_IDLE and the hold register to 0.
  - While reset=1: stallm=0 and dmem_we=0.
  - Reset asserted in ARB_SECOND aborts the EVEN access; no write occurs.
- stallm depends combinationally on state and the memreq inputs. It must not depend on dmem_rd.

## Configuration
- DMEM_LOADMERGE_EN defined:
  - When both lanes load (memwrite=0) and aluoutmODD[31:2]==aluoutmEVEN[31:2], no conflict is declared.
  - One access is made with the ODD address; both readdata outputs = dmem_rd, stallm=0, and the state stays ARB_IDLE.
- DMEM_LOADMERGE_EN undefined: every dual request is a conflict, including same-word load pairs.

## Structure
- Shared package dmem_arb_pkg holds:
  - the state typedef (ARB_IDLE, ARB_SECOND, 1-bit encoding);
  - lane-select constants LANE_ODD=0 and LANE_EVEN=1.
- No new sub-module. The hold register is the existing flopenr #(32), and the lane-select muxing uses the existing mux2.

## Test plan
- ODD-only load: ODD loads 0x40 holding 0xDEADBEEF, EVEN idle → readdatamODD=0xDEADBEEF in the same cycle, stallm=0, dmem_we=0.
- EVEN-only store: EVEN stores 0x1234 to 0x80 → dmem_a=0x80, dmem_we=1, stallm=0. A following ODD load of 0x80 returns 0x1234.
- Dual load conflict: ODD loads 0x10 (=0xA), EVEN loads 0x20 (=0xB) → cycle 1: stallm=1, dmem_a=0x10. Cycle 2: dmem_a=0x20, readdatamODD=0xA, readdatamEVEN=0xB.
- Store-load order: ODD stores 0x55 to 0x30, EVEN loads 0x30 → cycle 1 writes 0x55. Cycle 2 readdatamEVEN=0x55.
- Same-word loads at 0x44 and 0x44: macro defined → stallm=0 and both read the same value. Macro undefined → two-cycle sequence.
- Reset asserted in ARB_SECOND with EVEN storing → dmem_we=0 that cycle, state returns to ARB_IDLE, stallm=0, and memory is unchanged.
